// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle MIPS DIV/DIVU unit.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int unsigned DIV_ITERS = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted  = {rem[WIDTH-1:0], next_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = (shifted >= {1'b0, divisor});
    rem_next = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/div_unit.sv
// 32-cycle restoring divider for MIPS DIV/DIVU; drives the ALU_stall/ALU_done handshake.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             ALU_stall,
  output logic             ALU_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   r;
  logic             qsign;
  logic             rsign;
  logic             div0;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_next;
  logic             a_neg;
  logic             b_neg;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (r),
    .next_bit (a_sh[WIDTH-1]),
    .divisor  (b_r),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    q_next = {q[WIDTH-2:0], step_q};
    a_neg  = div_signed && dividend[WIDTH-1];
    b_neg  = div_signed && divisor[WIDTH-1];
  end

  always_comb begin
    ALU_stall = 1'b0;
    if (!cancel) begin
      unique case (state)
        IDLE:    ALU_stall = div_start;
        CALC:    ALU_stall = 1'b1;
        FIX:     ALU_stall = 1'b1;
        default: ALU_stall = 1'b0;
      endcase
    end
  end

  // The final sign fix is registered on the last CALC step so hi/lo are
  // already valid in the FIX cycle alongside ALU_done.
  // Divide by zero: restoring steps leave r = |a|, and the remainder sign fix
  // restores the original dividend, so only the quotient needs forcing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_sh     <= '0;
      b_r      <= '0;
      q        <= '0;
      r        <= '0;
      qsign    <= 1'b0;
      rsign    <= 1'b0;
      div0     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      ALU_done <= 1'b0;
    end else if (cancel) begin
      state    <= IDLE;
      ALU_done <= 1'b0;
    end else begin
      ALU_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (div_start) begin
            a_sh  <= a_neg ? -dividend : dividend;
            b_r   <= b_neg ? -divisor : divisor;
            qsign <= a_neg ^ b_neg;
            rsign <= a_neg;
            div0  <= (divisor == '0);
            r     <= '0;
            q     <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          a_sh <= {a_sh[WIDTH-2:0], 1'b0};
          r    <= step_rem;
          q    <= q_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_ITERS - 1)) begin
            lo       <= div0 ? '1 : (qsign ? -q_next : q_next);
            hi       <= rsign ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
            ALU_done <= 1'b1;
            state    <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed MIPS corner cases plus random operands.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        ALU_stall;
  logic        ALU_done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .cancel     (cancel),
    .ALU_stall  (ALU_stall),
    .ALU_done   (ALU_done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // MIPS semantics from plain arithmetic: truncating quotient, remainder takes dividend sign.
  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] e_hi, output logic [31:0] e_lo);
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      e_hi = a;
      e_lo = 32'hFFFF_FFFF;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      e_lo = qq[31:0];
      e_hi = rr[31:0];
    end else begin
      e_lo = a / b;
      e_hi = a % b;
    end
  endtask

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_hi, input logic [31:0] e_lo, input bit poke);
    int done_at;
    bit stall_ok;
    @(negedge clk);
    div_signed = s; dividend = a; divisor = b; div_start = 1'b1;
    #1 check("stall_start", 32'(ALU_stall), 32'd1);
    done_at  = 0;
    stall_ok = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      div_start = (poke && k == 5);
      if (poke && k == 5) begin
        dividend   = ~a;
        divisor    = b + 32'd3;
        div_signed = ~s;
      end
      #1;
      if (!ALU_stall) stall_ok = 1'b0;
      if (ALU_done && done_at == 0) done_at = k;
    end
    check("done_cycle", 32'(done_at), 32'd33);
    check("stall_busy", 32'(stall_ok), 32'd1);
    check("hi", hi, e_hi);
    check("lo", lo, e_lo);
    @(negedge clk);
    #1;
    check("done_drop", 32'(ALU_done), 32'd0);
    check("stall_drop", 32'(ALU_stall), 32'd0);
    check("hi_hold", hi, e_hi);
    check("lo_hold", lo, e_lo);
  endtask

  task automatic run_rand(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e_hi, e_lo;
    model(s, a, b, e_hi, e_lo);
    run_div(s, a, b, e_hi, e_lo, 1'b0);
  endtask

  initial begin
    logic [31:0] p_hi, p_lo, a, b;
    bit seen_done;
    rst = 1'b1; div_start = 1'b0; div_signed = 1'b0;
    dividend = '0; divisor = '0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_done", 32'(ALU_done), 32'd0);
    check("rst_stall", 32'(ALU_stall), 32'd0);
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_div(1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_div(1'b1, 32'd7, -32'sd2, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_div(1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    run_div(1'b1, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    run_div(1'b1, 32'h8765_4321, 32'd0, 32'h8765_4321, 32'hFFFF_FFFF, 1'b0);
    // Start pulse with different operands while busy must not disturb the result.
    run_div(1'b0, 32'd1000, 32'd9, 32'd1, 32'd111, 1'b1);

    // Cancel mid-divide at T+10, restart at T+12.
    p_hi = hi; p_lo = lo;
    seen_done = 1'b0;
    @(negedge clk);
    div_signed = 1'b0; dividend = 32'd5000; divisor = 32'd3; div_start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      div_start = 1'b0;
      cancel = (k == 10);
      #1;
      if (ALU_done) seen_done = 1'b1;
      if (k == 10) check("cancel_stall", 32'(ALU_stall), 32'd0);
    end
    check("cancel_nodone", 32'(seen_done), 32'd0);
    check("cancel_idle_stall", 32'(ALU_stall), 32'd0);
    check("cancel_hi", hi, p_hi);
    check("cancel_lo", lo, p_lo);
    run_div(1'b0, 32'd5000, 32'd3, 32'd2, 32'd1666, 1'b0);

    // Cancel together with start: start ignored.
    seen_done = 1'b0;
    @(negedge clk);
    div_start = 1'b1; cancel = 1'b1; dividend = 32'd77; divisor = 32'd5;
    #1 check("cancel_start_stall", 32'(ALU_stall), 32'd0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      div_start = 1'b0; cancel = 1'b0;
      #1;
      if (ALU_done || ALU_stall) seen_done = 1'b1;
    end
    check("cancel_start_ignored", 32'(seen_done), 32'd0);
    check("cancel_start_lo", lo, 32'd1666);

    // Reset at T+20 mid-divide.
    seen_done = 1'b0;
    @(negedge clk);
    div_signed = 1'b0; dividend = 32'd999; divisor = 32'd4; div_start = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      div_start = 1'b0;
      rst = (k == 20);
      #1;
      if (ALU_done) seen_done = 1'b1;
    end
    rst = 1'b0;
    check("midrst_nodone", 32'(seen_done), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_stall", 32'(ALU_stall), 32'd0);

    for (int i = 0; i < 50; i++) begin
      a = $urandom;
      case (i % 5)
        0: b = $urandom_range(1, 15);
        1: b = 32'd0;
        2: b = -($urandom_range(1, 200));
        default: b = $urandom;
      endcase
      if (i % 7 == 0) a = 32'h8000_0000;
      run_rand(1'(i % 2), a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for MIPS DIV/DIVU, sitting in EX beside the single-cycle ALU.
- Drives the ALU_stall / ALU_done pair consumed by the hazard detection/control block, which holds F/D/E while the divide is in flight.
- Produces the HI (remainder) and LO (quotient) results written at instruction completion.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous reset, active-high.
- div_start  in  1  EX holds a DIV/DIVU instruction; sampled only in IDLE.
- div_signed  in  1  1 = DIV (two's-complement), 0 = DIVU; captured with div_start.
- dividend  in  WIDTH  rs operand (post-forwarding); captured with div_start.
- divisor  in  WIDTH  rt operand (post-forwarding); captured with div_start.
- cancel  in  1  exception flush; aborts any operation in flight.
- ALU_stall  out  1  divider needs the pipeline held.
- ALU_done  out  1  single-cycle pulse; hi/lo are valid this cycle.
- hi  out  WIDTH  remainder, registered.
- lo  out  WIDTH  quotient, registered.

Behaviour:
- Reset:
  - State goes to IDLE.
  - hi = 0, lo = 0, ALU_done = 0, ALU_stall = 0, counter = 0.
  - Reset asserted mid-operation abandons the operation with no done pulse.
- States: IDLE, CALC, FIX.
- IDLE:
  - When div_start && !cancel: latch |dividend| and |divisor| (abs only if div_signed), latch the quotient sign (sign_a ^ sign_b) and the remainder sign (sign_a), clear the 33-bit partial remainder, counter = 0, go to CALC.
  - ALU_stall = div_start && !cancel, combinational, so the hazard unit freezes in the start cycle T.
- CALC:
  - One restoring step per cycle, MSB first:
    - r' = {r[31:0], a[31]}; shift a left.
    - If r' >= {1'b0, b}: r = r' - b and q bit = 1; else r = r' and q bit = 0.
  - Counter increments each cycle. After the step with counter == 31 (cycle T+32), go to FIX.
  - ALU_stall = 1.
- FIX (cycle T+33):
  - Register lo = qsign ? -q : q and hi = rsign ? -r[31:0] : r[31:0]. Negation is WIDTH-bit two's-complement.
  - ALU_done = 1 and ALU_stall = 1 (the hazard unit sees stall && done and releases). Next state IDLE.
- Latency: done is asserted exactly 33 cycles after the start cycle. hi/lo hold their value until the next FIX.
- Divide by zero: same latency. The result is forced to hi = original dividend and lo = {WIDTH{1'b1}}, regardless of div_signed.
- Overflow case 0x80000000 / -1 (signed): natural result, lo = 0x80000000, hi = 0. abs(0x80000000) is treated as the unsigned value 2^31.
- cancel:
  - Highest priority in every state.
  - Next state is IDLE with no ALU_done pulse; hi/lo are unchanged.
  - ALU_stall is forced 0 in the cycle cancel is high.
  - cancel with div_start in the same cycle: the start is ignored.
- div_start while in CALC/FIX is ignored; operands are not re-captured.
- div_start held high in the cycle after FIX (the instruction has not yet left EX) must not restart. EX is released by the hazard unit in that cycle, and the pipeline guarantees div_start drops when the instruction advances. div_unit does not filter this itself.

Decomposition:
- Shared package (div_pkg): state encoding localparams (IDLE=2'd0, CALC=2'd1, FIX=2'd2) and DIV_ITERS = 32.
- Sub-module div_step: purely combinational single restoring iteration. Inputs are partial remainder, next dividend bit and divisor; outputs are the new remainder and the quotient bit. div_unit instantiates it once.

Test Plan:
- DIVU 100 / 7, start at T -> ALU_stall high T..T+33, ALU_done only at T+33, lo = 14, hi = 2.
- DIV -7 / 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). DIV 7 / -2 -> lo = -3, hi = 1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0. DIVU same operands -> lo = 0, hi = 0x80000000.
- Divide by zero, dividend 0x12345678, either signedness -> done at T+33, hi = 0x12345678, lo = 0xFFFFFFFF.
- cancel at T+10 -> state IDLE at T+11, no done pulse, hi/lo keep prior values. New start at T+12 completes normally at T+45.
- rst at T+20 mid-divide -> all outputs 0 next cycle. div_start asserted while in CALC -> ignored, original result still delivered at T+33.
